// File: rtl/dta_ingr_snd_arbiter_if.sv
// Request, response and data channel bundle between the ingress send arbiter,
// the selected requester's data path and the shared downstream channels.
interface dta_ingr_snd_arbiter_if;
  logic         req_tvalid;
  logic         req_tready;
  logic [63:0]  req_tdata;
  logic         resp_tvalid;
  logic         resp_tready;
  logic [63:0]  resp_tdata;
  logic         s_data_tvalid;
  logic         s_data_tready;
  logic [511:0] s_data_tdata;
  logic         data_tvalid;
  logic         data_tready;
  logic [511:0] data_tdata;

  modport master (
    output req_tvalid, req_tdata, resp_tready, s_data_tready, data_tvalid, data_tdata,
    input  req_tready, resp_tvalid, resp_tdata, s_data_tvalid, s_data_tdata, data_tready
  );

  modport slave (
    input  req_tvalid, req_tdata, resp_tready, s_data_tready, data_tvalid, data_tdata,
    output req_tready, resp_tvalid, resp_tdata, s_data_tvalid, s_data_tdata, data_tready
  );
endinterface

// File: rtl/dta_ingr_snd_arbiter.sv
// Round-robin arbiter/sequencer: one req, one resp, then the granted data beats per grant.
// Define DTA_INGR_SND_ARB_RESP_CHECK_EN to enable response checks and sticky arb_error.
module dta_ingr_snd_arbiter #(
  parameter int          CH_NUM    = 8,
  parameter int          CH_W      = 3,
  parameter logic [15:0] MAX_BURST = 16'd64
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  input  logic [CH_NUM-1:0]    ch_req_valid,
  input  logic [CH_NUM*16-1:0] ch_req_burst,
  input  logic [CH_NUM-1:0]    ch_req_sof,
  input  logic [CH_NUM-1:0]    ch_req_eof,
  output logic [CH_NUM-1:0]    ch_req_ready,
  dta_ingr_snd_arbiter_if.master bus,
  output logic                 grant_valid,
  output logic [CH_W-1:0]      grant_ch,
  output logic [15:0]          grant_burst,
  output logic [CH_W-1:0]      data_sel,
  output logic [3:0]           arb_error,
  output logic                 arb_error_ap_vld
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DATA} state_t;

  state_t            state_q, state_d;
  logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [15:0]       burst_q, burst_d;
  logic              sof_q, sof_d;
  logic              eof_q, eof_d;
  logic [15:0]       beat_cnt_q, beat_cnt_d;
  logic [CH_NUM-1:0] ch_req_ready_q, ch_req_ready_d;
  logic              grant_valid_q, grant_valid_d;
  logic [CH_W-1:0]   grant_ch_q, grant_ch_d;
  logic [15:0]       grant_burst_q, grant_burst_d;
  logic [3:0]        err_q, err_d;
  logic              err_vld_q, err_vld_d;

  logic              found;
  logic [CH_W-1:0]   pick;
  logic [15:0]       pick_burst;
  logic [15:0]       burst_arr [CH_NUM];
  logic [15:0]       resp_burst;
  logic [15:0]       resp_beats;
  logic [3:0]        err_new;
  logic              unused_resp;

  for (genvar g = 0; g < CH_NUM; g++) begin : g_burst
    assign burst_arr[g] = ch_req_burst[16*g +: 16];
  end

  assign resp_burst  = bus.resp_tdata[63:48];
  assign unused_resp = ^bus.resp_tdata[47:0];

  // Scan upward from the channel after the last winner, wrapping modulo CH_NUM.
  always_comb begin
    int idx;
    logic [CH_W-1:0] idx_w;
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    idx_w = '0;
    for (int i = 1; i <= CH_NUM; i++) begin
      idx   = (int'(rr_ptr_q) + i) % CH_NUM;
      idx_w = CH_W'(idx);
      if (!found && ch_req_valid[idx_w]) begin
        found = 1'b1;
        pick  = idx_w;
      end
    end
    pick_burst = burst_arr[pick];
    if (pick_burst == 16'd0) begin
      pick_burst = 16'd1;
    end else if (pick_burst > MAX_BURST) begin
      pick_burst = MAX_BURST;
    end
  end

  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    ch_d           = ch_q;
    burst_d        = burst_q;
    sof_d          = sof_q;
    eof_d          = eof_q;
    beat_cnt_d     = beat_cnt_q;
    ch_req_ready_d = '0;
    grant_valid_d  = 1'b0;
    grant_ch_d     = grant_ch_q;
    grant_burst_d  = grant_burst_q;
    err_new        = '0;
    resp_beats     = resp_burst;
    case (state_q)
      IDLE: begin
        if (found) begin
          ch_d    = pick;
          burst_d = pick_burst;
          sof_d   = ch_req_sof[pick];
          eof_d   = ch_req_eof[pick];
          state_d = REQ;
        end
      end
      REQ: begin
        if (bus.req_tready) begin
          ch_req_ready_d = CH_NUM'(1) << ch_q;
          rr_ptr_d       = ch_q;
          state_d        = RESP;
        end
      end
      RESP: begin
        if (bus.resp_tvalid) begin
`ifdef DTA_INGR_SND_ARB_RESP_CHECK_EN
          err_new[0] = bus.resp_tdata[15:0] != 16'(ch_q);
          err_new[1] = resp_burst > burst_q;
          err_new[2] = bus.resp_tdata[33] != sof_q;
          err_new[3] = bus.resp_tdata[34] != eof_q;
          if (err_new[1]) begin
            resp_beats = burst_q;
          end
`endif
          grant_valid_d = 1'b1;
          grant_ch_d    = ch_q;
          grant_burst_d = resp_burst;
          beat_cnt_d    = resp_beats;
          state_d       = (resp_beats == 16'd0) ? IDLE : DATA;
        end
      end
      DATA: begin
        if (bus.s_data_tvalid && bus.data_tready) begin
          beat_cnt_d = beat_cnt_q - 16'd1;
          if (beat_cnt_q == 16'd1) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // err_new stays zero when the checks are compiled out, so the flags stay tied low.
    err_d     = err_q | err_new;
    err_vld_d = |(err_new & ~err_q);
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state_q        <= IDLE;
      rr_ptr_q       <= CH_W'(CH_NUM - 1);
      ch_q           <= '0;
      burst_q        <= '0;
      sof_q          <= 1'b0;
      eof_q          <= 1'b0;
      beat_cnt_q     <= '0;
      ch_req_ready_q <= '0;
      grant_valid_q  <= 1'b0;
      grant_ch_q     <= '0;
      grant_burst_q  <= '0;
      err_q          <= '0;
      err_vld_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      ch_q           <= ch_d;
      burst_q        <= burst_d;
      sof_q          <= sof_d;
      eof_q          <= eof_d;
      beat_cnt_q     <= beat_cnt_d;
      ch_req_ready_q <= ch_req_ready_d;
      grant_valid_q  <= grant_valid_d;
      grant_ch_q     <= grant_ch_d;
      grant_burst_q  <= grant_burst_d;
      err_q          <= err_d;
      err_vld_q      <= err_vld_d;
    end
  end

  assign bus.req_tvalid    = (state_q == REQ);
  assign bus.req_tdata     = (state_q == REQ) ?
                             {burst_q, 13'd0, eof_q, sof_q, 17'd0, 16'(ch_q)} : 64'd0;
  assign bus.resp_tready   = (state_q == RESP);
  assign bus.data_tvalid   = (state_q == DATA) && bus.s_data_tvalid;
  assign bus.data_tdata    = (state_q == DATA) ? bus.s_data_tdata : '0;
  assign bus.s_data_tready = (state_q == DATA) && bus.data_tready;

  assign ch_req_ready     = ch_req_ready_q;
  assign grant_valid      = grant_valid_q;
  assign grant_ch         = grant_ch_q;
  assign grant_burst      = grant_burst_q;
  assign data_sel         = ch_q;
  assign arb_error        = err_q;
  assign arb_error_ap_vld = err_vld_q;

endmodule
